// File: rtl/cpu_ldst_responder_if.sv
// CPU-facing fetch/load-store port and peripheral bus of the memory responder.
// The slave modport is the responder's view; master is the CPU/peripheral side.
interface cpu_ldst_responder_if;
   logic        i_pc_rd;
   logic [15:0] i_pc_addr;
   logic [15:0] o_pc_rddata;
   logic        i_ldst_rd;
   logic        i_ldst_wr;
   logic [15:0] i_ldst_addr;
   logic [15:0] i_ldst_wrdata;
   logic [15:0] o_ldst_rddata;
   logic        o_ldst_waitrequest;
   logic        o_per_req;
   logic        o_per_we;
   logic [15:0] o_per_addr;
   logic [15:0] o_per_wrdata;
   logic        i_per_ack;
   logic [15:0] i_per_rddata;
   logic        o_bus_err;
   logic        i_err_clr;

   modport slave (
      input  i_pc_rd, i_pc_addr, i_ldst_rd, i_ldst_wr, i_ldst_addr, i_ldst_wrdata,
             i_per_ack, i_per_rddata, i_err_clr,
      output o_pc_rddata, o_ldst_rddata, o_ldst_waitrequest, o_per_req, o_per_we,
             o_per_addr, o_per_wrdata, o_bus_err
   );

   modport master (
      output i_pc_rd, i_pc_addr, i_ldst_rd, i_ldst_wr, i_ldst_addr, i_ldst_wrdata,
             i_per_ack, i_per_rddata, i_err_clr,
      input  o_pc_rddata, o_ldst_rddata, o_ldst_waitrequest, o_per_req, o_per_we,
             o_per_addr, o_per_wrdata, o_bus_err
   );
endinterface

// File: rtl/cpu_ldst_responder.sv
// Word RAM serving CPU fetches and data accesses; data accesses in the MMIO
// window are forwarded to the peripheral bus while the CPU is stalled.
module cpu_ldst_responder #(
   parameter int          RAM_WORDS = 4096,
   parameter logic [15:0] MMIO_BASE = 16'hF000,
   parameter int          TIMEOUT   = 16
) (
   input logic                 i_clk,
   input logic                 i_reset,
   cpu_ldst_responder_if.slave bus
);
   localparam int         AW       = $clog2(RAM_WORDS);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, M_REQ, M_DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] ram [RAM_WORDS];
   logic [7:0]  tmo_cnt;
   logic        wait_req;
   logic        req;
   logic        is_wr;
   logic        mmio_hit;
   logic        accept;
   logic        ram_rd;
   logic        ram_wr;
   logic        launch;
   logic        ack_hit;
   logic        tmo_fire;
   logic        per_req;
   logic        per_we;
   logic [15:0] per_addr;
   logic [15:0] per_wrdata;
   logic [15:0] pc_rddata;
   logic [15:0] ldst_rddata;
   logic        bus_err;
   logic [AW-1:0] pc_idx;
   logic [AW-1:0] ldst_idx;
   logic        unused_addr_bits;

   // A simultaneous read and write strobe is treated as a write.
   assign req      = bus.i_ldst_rd | bus.i_ldst_wr;
   assign is_wr    = bus.i_ldst_wr;
   assign mmio_hit = bus.i_ldst_addr >= MMIO_BASE;
   assign accept   = req & ~wait_req;
   assign ram_rd   = accept & ~mmio_hit & ~is_wr;
   assign ram_wr   = accept & ~mmio_hit & is_wr;
   assign launch   = (state == IDLE) & req & mmio_hit;
   assign ack_hit  = (state == M_REQ) & bus.i_per_ack;
   assign tmo_fire = (state == M_REQ) & ~bus.i_per_ack & (tmo_cnt == TMO_LAST);
   assign pc_idx   = bus.i_pc_addr[AW:1];
   assign ldst_idx = bus.i_ldst_addr[AW:1];
   assign unused_addr_bits = ^{bus.i_pc_addr, bus.i_ldst_addr[0]};

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = M_REQ;
         M_REQ:   if (ack_hit || tmo_fire) state_nxt = M_DONE;
         M_DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // M_DONE deasserts the stall so the CPU's held MMIO request retires there.
   always_comb begin
      wait_req = 1'b0;
      case (state)
         IDLE:    wait_req = req & mmio_hit;
         M_REQ:   wait_req = 1'b1;
         default: wait_req = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         per_req     <= 1'b0;
         per_we      <= 1'b0;
         per_addr    <= '0;
         per_wrdata  <= '0;
         tmo_cnt     <= '0;
         ldst_rddata <= '0;
         pc_rddata   <= '0;
         bus_err     <= 1'b0;
      end else begin
         if (launch) begin
            per_req    <= 1'b1;
            per_we     <= is_wr;
            per_addr   <= bus.i_ldst_addr;
            per_wrdata <= bus.i_ldst_wrdata;
            tmo_cnt    <= '0;
         end else if (state == M_REQ) begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (ack_hit || tmo_fire)
               per_req <= 1'b0;
         end

         if (ram_rd)
            ldst_rddata <= ram[ldst_idx];
         else if (ack_hit && !per_we)
            ldst_rddata <= bus.i_per_rddata;
         else if (tmo_fire && !per_we)
            ldst_rddata <= 16'hDEAD;

         if (tmo_fire)
            bus_err <= 1'b1;
         else if (bus.i_err_clr)
            bus_err <= 1'b0;

         if (bus.i_pc_rd)
            pc_rddata <= ram[pc_idx];
      end
   end

   // Reads above sample the pre-edge contents, giving read-before-write.
   always_ff @(posedge i_clk) begin
      if (ram_wr)
         ram[ldst_idx] <= bus.i_ldst_wrdata;
   end

   assign bus.o_pc_rddata        = pc_rddata;
   assign bus.o_ldst_rddata      = ldst_rddata;
   assign bus.o_ldst_waitrequest = wait_req;
   assign bus.o_per_req          = per_req;
   assign bus.o_per_we           = per_we;
   assign bus.o_per_addr         = per_addr;
   assign bus.o_per_wrdata       = per_wrdata;
   assign bus.o_bus_err          = bus_err;
endmodule

// File: tb/tb_cpu_ldst_responder.sv
// Scoreboard bench for cpu_ldst_responder: RAM paths, fetch conflicts,
// MMIO handshake, timeout/error flag and reset during an MMIO access.
module tb_cpu_ldst_responder;
   logic i_clk = 1'b0;
   logic i_reset;
   int   checks = 0;
   int   passes = 0;
   logic [15:0] exp_q[$];

   cpu_ldst_responder_if bus();

   cpu_ldst_responder #(
      .RAM_WORDS(4096),
      .MMIO_BASE(16'hF000),
      .TIMEOUT(4)
   ) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .bus(bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic idle_inputs();
      bus.i_pc_rd = 0; bus.i_pc_addr = '0;
      bus.i_ldst_rd = 0; bus.i_ldst_wr = 0; bus.i_ldst_addr = '0; bus.i_ldst_wrdata = '0;
      bus.i_per_ack = 0; bus.i_per_rddata = '0; bus.i_err_clr = 0;
   endtask

   task automatic ram_write(input logic [15:0] addr, input logic [15:0] data);
      @(negedge i_clk);
      bus.i_ldst_wr = 1; bus.i_ldst_addr = addr; bus.i_ldst_wrdata = data;
      @(negedge i_clk);
      bus.i_ldst_wr = 0;
   endtask

   task automatic ram_read(input logic [15:0] addr, input logic [15:0] expected);
      @(negedge i_clk);
      bus.i_ldst_rd = 1; bus.i_ldst_addr = addr;
      exp_q.push_back(expected);
      @(negedge i_clk);
      bus.i_ldst_rd = 0;
   endtask

   // Holds a data request until accepted, acking in the ack_at-th M_REQ cycle (0 = never).
   task automatic do_mmio(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input int ack_at, input logic [15:0] ack_data,
                          output int wait_cnt, output int req_cnt,
                          output logic [32:0] seen, output logic done);
      wait_cnt = 0; req_cnt = 0; seen = '0; done = 0;
      @(negedge i_clk);
      bus.i_ldst_rd = ~we; bus.i_ldst_wr = we; bus.i_ldst_addr = addr; bus.i_ldst_wrdata = wdata;
      for (int cyc = 0; cyc < 40; cyc++) begin
         #1;
         bus.i_per_ack = 0;
         if (bus.o_per_req) begin
            req_cnt++;
            if (req_cnt == 1) seen = {bus.o_per_we, bus.o_per_addr, bus.o_per_wrdata};
            if (req_cnt == ack_at) begin
               bus.i_per_ack = 1; bus.i_per_rddata = ack_data;
            end
         end
         if (bus.o_ldst_waitrequest) wait_cnt++;
         else begin
            done = 1;
            break;
         end
         @(negedge i_clk);
      end
      @(negedge i_clk);
      bus.i_ldst_rd = 0; bus.i_ldst_wr = 0; bus.i_per_ack = 0;
      #1;
   endtask

   task automatic test_reset();
      logic [67:0] outs;
      i_reset = 0;
      #2;
      outs = {bus.o_per_req, bus.o_per_we, bus.o_per_addr, bus.o_per_wrdata, bus.o_pc_rddata,
              bus.o_ldst_rddata, bus.o_bus_err, bus.o_ldst_waitrequest};
      checks++;
      if (outs !== '0) $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
      else passes++;
      @(negedge i_clk);
      i_reset = 1;
   endtask

   task automatic test_ram_rw();
      logic [15:0] exp;
      @(negedge i_clk);
      bus.i_ldst_wr = 1; bus.i_ldst_addr = 16'h0010; bus.i_ldst_wrdata = 16'h1234;
      #1;
      checks++;
      if (bus.o_ldst_waitrequest !== 1'b0) $display("[TB] FAIL ram_wr_wait: got %b expected 0", bus.o_ldst_waitrequest);
      else passes++;
      @(negedge i_clk);
      bus.i_ldst_wr = 0; bus.i_ldst_rd = 1;
      exp_q.push_back(16'h1234);
      #1;
      checks++;
      if (bus.o_ldst_waitrequest !== 1'b0) $display("[TB] FAIL ram_rd_wait: got %b expected 0", bus.o_ldst_waitrequest);
      else passes++;
      @(negedge i_clk);
      bus.i_ldst_rd = 0;
      exp = exp_q.pop_front();
      checks++;
      if (bus.o_ldst_rddata !== exp) $display("[TB] FAIL ram_rd_data: got %h expected %h", bus.o_ldst_rddata, exp);
      else passes++;
   endtask

   task automatic test_fetch_conflict();
      ram_write(16'h0020, 16'h0000);
      @(negedge i_clk);
      bus.i_pc_rd = 1; bus.i_pc_addr = 16'h0020;
      bus.i_ldst_wr = 1; bus.i_ldst_addr = 16'h0020; bus.i_ldst_wrdata = 16'hBEEF;
      @(negedge i_clk);
      bus.i_ldst_wr = 0; bus.i_pc_addr = 16'h0021;
      checks++;
      if (bus.o_pc_rddata !== 16'h0000) $display("[TB] FAIL fetch_rbw: got %h expected 0000", bus.o_pc_rddata);
      else passes++;
      @(negedge i_clk);
      bus.i_pc_rd = 0;
      checks++;
      if (bus.o_pc_rddata !== 16'hBEEF) $display("[TB] FAIL fetch_new: got %h expected beef", bus.o_pc_rddata);
      else passes++;
      bus.i_pc_addr = 16'h0010;
      @(negedge i_clk);
      checks++;
      if (bus.o_pc_rddata !== 16'hBEEF) $display("[TB] FAIL fetch_hold: got %h expected beef", bus.o_pc_rddata);
      else passes++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] waddr[3] = '{16'h0100, 16'h0102, 16'h0104};
      logic [15:0] wdat[3]  = '{16'h1111, 16'h2222, 16'h3333};
      logic [15:0] raddr[4] = '{16'h0100, 16'h0103, 16'h0104, 16'h2010};
      logic [15:0] rexp[4]  = '{16'h1111, 16'h2222, 16'h3333, 16'h1234};
      logic [15:0] exp;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         bus.i_ldst_wr = 1; bus.i_ldst_addr = waddr[i]; bus.i_ldst_wrdata = wdat[i];
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         bus.i_ldst_wr = 0;
         if (i > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.o_ldst_rddata !== exp) $display("[TB] FAIL b2b_rd%0d: got %h expected %h", i - 1, bus.o_ldst_rddata, exp);
            else passes++;
         end
         if (i < 4) begin
            bus.i_ldst_rd = 1; bus.i_ldst_addr = raddr[i];
            exp_q.push_back(rexp[i]);
         end else bus.i_ldst_rd = 0;
      end
   endtask

   task automatic test_mmio_read();
      int w, r; logic [32:0] seen; logic done; logic [15:0] exp;
      exp_q.push_back(16'h00A5);
      do_mmio(1'b0, 16'hF004, 16'h0000, 3, 16'h00A5, w, r, seen, done);
      checks++;
      if (done !== 1'b1) $display("[TB] FAIL mrd_accept: got %b expected 1 (timed out)", done);
      else passes++;
      checks++;
      if (w != 4) $display("[TB] FAIL mrd_wait_cycles: got %0d expected 4", w);
      else passes++;
      checks++;
      if (r != 3) $display("[TB] FAIL mrd_req_cycles: got %0d expected 3", r);
      else passes++;
      checks++;
      if (seen !== {1'b0, 16'hF004, 16'h0000}) $display("[TB] FAIL mrd_per_bus: got %h expected %h", seen, {1'b0, 16'hF004, 16'h0000});
      else passes++;
      exp = exp_q.pop_front();
      checks++;
      if (bus.o_ldst_rddata !== exp) $display("[TB] FAIL mrd_data: got %h expected %h", bus.o_ldst_rddata, exp);
      else passes++;
   endtask

   task automatic test_mmio_write();
      int w, r; logic [32:0] seen; logic done; logic [15:0] exp;
      ram_write(16'h1000, 16'h7777);
      do_mmio(1'b1, 16'hF000, 16'h5555, 1, 16'h0000, w, r, seen, done);
      checks++;
      if (w != 2 || r != 1) $display("[TB] FAIL mwr_cycles: got wait=%0d req=%0d expected wait=2 req=1", w, r);
      else passes++;
      checks++;
      if (seen !== {1'b1, 16'hF000, 16'h5555}) $display("[TB] FAIL mwr_per_bus: got %h expected %h", seen, {1'b1, 16'hF000, 16'h5555});
      else passes++;
      checks++;
      if (bus.o_ldst_rddata !== 16'h00A5) $display("[TB] FAIL mwr_rddata_hold: got %h expected 00a5", bus.o_ldst_rddata);
      else passes++;
      checks++;
      if (bus.o_per_addr !== 16'hF000 || bus.o_per_we !== 1'b1) $display("[TB] FAIL mwr_per_hold: got %h/%b expected f000/1", bus.o_per_addr, bus.o_per_we);
      else passes++;
      ram_read(16'h1000, 16'h7777);
      exp = exp_q.pop_front();
      checks++;
      if (bus.o_ldst_rddata !== exp) $display("[TB] FAIL mwr_ram_untouched: got %h expected %h", bus.o_ldst_rddata, exp);
      else passes++;
   endtask

   task automatic test_timeout();
      int w, r; logic [32:0] seen; logic done; logic [15:0] exp;
      exp_q.push_back(16'hDEAD);
      do_mmio(1'b0, 16'hF008, 16'h0000, 0, 16'h0000, w, r, seen, done);
      checks++;
      if (w != 5 || r != 4) $display("[TB] FAIL tmo_cycles: got wait=%0d req=%0d expected wait=5 req=4", w, r);
      else passes++;
      exp = exp_q.pop_front();
      checks++;
      if (bus.o_ldst_rddata !== exp) $display("[TB] FAIL tmo_data: got %h expected %h", bus.o_ldst_rddata, exp);
      else passes++;
      checks++;
      if (bus.o_bus_err !== 1'b1) $display("[TB] FAIL tmo_err_set: got %b expected 1", bus.o_bus_err);
      else passes++;
      @(negedge i_clk);
      bus.i_per_ack = 1; bus.i_per_rddata = 16'h1111;
      @(negedge i_clk);
      bus.i_per_ack = 0;
      #1;
      checks++;
      if ({bus.o_per_req, bus.o_ldst_waitrequest, bus.o_ldst_rddata, bus.o_bus_err} !== {2'b00, 16'hDEAD, 1'b1})
         $display("[TB] FAIL late_ack_ignored: got req=%b wait=%b data=%h err=%b expected 0 0 dead 1",
                  bus.o_per_req, bus.o_ldst_waitrequest, bus.o_ldst_rddata, bus.o_bus_err);
      else passes++;
      @(negedge i_clk);
      bus.i_err_clr = 1;
      @(negedge i_clk);
      bus.i_err_clr = 0;
      checks++;
      if (bus.o_bus_err !== 1'b0) $display("[TB] FAIL err_clear: got %b expected 0", bus.o_bus_err);
      else passes++;
      exp_q.push_back(16'h1357);
      do_mmio(1'b0, 16'hF00A, 16'h0000, 4, 16'h1357, w, r, seen, done);
      exp = exp_q.pop_front();
      checks++;
      if (bus.o_ldst_rddata !== exp || w != 5) $display("[TB] FAIL ack_at_timeout: got data=%h wait=%0d expected %h wait=5", bus.o_ldst_rddata, w, exp);
      else passes++;
      checks++;
      if (bus.o_bus_err !== 1'b0) $display("[TB] FAIL ack_beats_timeout_err: got %b expected 0", bus.o_bus_err);
      else passes++;
   endtask

   task automatic test_reset_mid_access();
      int r = 0; logic [67:0] outs; logic [15:0] exp;
      @(negedge i_clk);
      bus.i_ldst_rd = 1; bus.i_ldst_addr = 16'hF010;
      for (int cyc = 0; cyc < 10 && r < 2; cyc++) begin
         #1;
         if (bus.o_per_req) r++;
         if (r < 2) @(negedge i_clk);
      end
      checks++;
      if (r != 2) $display("[TB] FAIL rst_mid_reach: got %0d req cycles expected 2", r);
      else passes++;
      bus.i_ldst_rd = 0;
      i_reset = 0;
      #1;
      outs = {bus.o_per_req, bus.o_per_we, bus.o_per_addr, bus.o_per_wrdata, bus.o_pc_rddata,
              bus.o_ldst_rddata, bus.o_bus_err, bus.o_ldst_waitrequest};
      checks++;
      if (outs !== '0) $display("[TB] FAIL rst_mid_outputs: got %h expected 0", outs);
      else passes++;
      @(negedge i_clk);
      i_reset = 1;
      ram_read(16'h0010, 16'h1234);
      exp = exp_q.pop_front();
      checks++;
      if (bus.o_ldst_rddata !== exp || bus.o_per_req !== 1'b0) $display("[TB] FAIL rst_mid_recover: got %h req=%b expected %h req=0", bus.o_ldst_rddata, bus.o_per_req, exp);
      else passes++;
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_ram_rw();
      test_fetch_conflict();
      test_back_to_back();
      test_mmio_read();
      test_mmio_write();
      test_timeout();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
